seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits; successor to the single-digit hex encoder.

---
 rtl/seg7_scan_driver_pkg.sv | 24 ++
 rtl/seg7_hex_decode.sv | 34 +++
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment patterns for the hex display path, active-high {g,f,e,d,c,b,a}.
// Pure constants: no latency, no flow control.
// Imported by the decoder and the scan driver.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG7_HEX_0 = 7'b0111111;
  localparam logic [6:0] SEG7_HEX_1 = 7'b0000110;
  localparam logic [6:0] SEG7_HEX_2 = 7'b1011011;
  localparam logic [6:0] SEG7_HEX_3 = 7'b1001111;
  localparam logic [6:0] SEG7_HEX_4 = 7'b1100110;
  localparam logic [6:0] SEG7_HEX_5 = 7'b1101101;
  localparam logic [6:0] SEG7_HEX_6 = 7'b1111101;
  localparam logic [6:0] SEG7_HEX_7 = 7'b0000111;
  localparam logic [6:0] SEG7_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG7_HEX_9 = 7'b1101111;
  localparam logic [6:0] SEG7_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG7_HEX_B = 7'b1111100;
  localparam logic [6:0] SEG7_HEX_C = 7'b0111001;
  localparam logic [6:0] SEG7_HEX_D = 7'b1011110;
  localparam logic [6:0] SEG7_HEX_E = 7'b1111001;
  localparam logic [6:0] SEG7_HEX_F = 7'b1110001;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-high 7-segment pattern.
// Combinational, zero latency.
// No flow control.
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG7_BLANK;
    case (nib)
      4'h0: pat = SEG7_HEX_0;
      4'h1: pat = SEG7_HEX_1;
      4'h2: pat = SEG7_HEX_2;
      4'h3: pat = SEG7_HEX_3;
      4'h4: pat = SEG7_HEX_4;
      4'h5: pat = SEG7_HEX_5;
      4'h6: pat = SEG7_HEX_6;
      4'h7: pat = SEG7_HEX_7;
      4'h8: pat = SEG7_HEX_8;
      4'h9: pat = SEG7_HEX_9;
      4'hA: pat = SEG7_HEX_A;
      4'hB: pat = SEG7_HEX_B;
      4'hC: pat = SEG7_HEX_C;
      4'hD: pat = SEG7_HEX_D;
      4'hE: pat = SEG7_HEX_E;
      4'hF: pat = SEG7_HEX_F;
      default: pat = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with shadowed value, dp and leading-zero blanking.
// seg/dp/an/frame registered: one cycle behind idx/shadow state.
// No backpressure: load is always accepted, enable=0 darkens and freezes the scan.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic                    guard;

  logic                  tick;
  logic                  lit;
  logic [3:0]            nib;
  logic                  nib_dp;
  logic                  nib_blank;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [6:0]            pat;
  logic [6:0]            seg_pat;

  assign tick = enable && (presc == PRE_LAST);
  // guard is set for the first cycle of every slot so the old and new anodes never overlap
  assign lit  = enable && !guard;

  // Digit k is a leading zero when it and every digit to its left are zero
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run   = zero_run && (shadow_val[4*k +: 4] == 4'h0);
      lz_mask[k] = BLANK_LEADING && zero_run;
    end
  end

  always_comb begin
    nib       = 4'h0;
    nib_dp    = 1'b0;
    nib_blank = 1'b0;
    an_hot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib       = shadow_val[4*k +: 4];
        nib_dp    = shadow_dp[k];
        nib_blank = lz_mask[k];
        an_hot[k] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nib (nib),
    .pat (pat)
  );

  assign seg_pat = nib_blank ? SEG7_BLANK : pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      presc      <= '0;
      idx        <= '0;
      guard      <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame      <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (enable) begin
        presc <= tick ? '0 : presc + PRE_W'(1);
        guard <= tick;
        if (tick) begin
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
      end
      frame <= tick && (idx == IDX_LAST);
      if (lit) begin
        seg <= seg_pat ^ SEG_OFF;
        dp  <= nib_dp ^ DP_OFF;
        an  <= an_hot ^ AN_OFF;
      end else begin
        seg <= SEG_OFF;
        dp  <= DP_OFF;
        an  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, three polarity/blanking builds.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0] seg, seg_hi, seg_nb;
  logic       dp, dp_hi, dp_nb;
  logic [3:0] an, an_hi, an_nb;
  logic       frame, frame_hi, frame_nb;

  int errors = 0;
  int checks = 0;

  logic [15:0] cur_val;
  logic [3:0]  cur_dp;
  logic [3:0]  cur_blank;
  logic [6:0]  tab [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg_hi), .dp(dp_hi), .an(an_hi), .frame(frame_hi)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_nb (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg_nb), .dp(dp_nb), .an(an_nb), .frame(frame_nb)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Sample cycles first..last after scanning (re)starts from digit 0, count 0.
  task automatic scan(input int first, input int last);
    int         k, p;
    logic       g;
    logic [3:0] nib, exp_an;
    logic [6:0] hx;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      k      = ((i - 1) / 4) % 4;
      p      = (i - 1) % 4;
      g      = (i > 4) && (p == 0);
      nib    = cur_val[4*k +: 4];
      hx     = tab[nib];
      exp_an = g ? 4'hF : ~(4'b0001 << k);
      chk($sformatf("an c%0d", i),       {3'b0, an},       {3'b0, exp_an});
      chk($sformatf("an_hi c%0d", i),    {3'b0, an_hi},    {3'b0, exp_an});
      chk($sformatf("an_nb c%0d", i),    {3'b0, an_nb},    {3'b0, exp_an});
      chk($sformatf("seg c%0d", i),      seg,    g ? 7'h7F : (cur_blank[k] ? 7'h7F : ~hx));
      chk($sformatf("seg_hi c%0d", i),   seg_hi, g ? 7'h00 : (cur_blank[k] ? 7'h00 : hx));
      chk($sformatf("seg_nb c%0d", i),   seg_nb, g ? 7'h7F : ~hx);
      chk($sformatf("dp c%0d", i),       {6'b0, dp},    {6'b0, g ? 1'b1 : ~cur_dp[k]});
      chk($sformatf("dp_hi c%0d", i),    {6'b0, dp_hi}, {6'b0, g ? 1'b0 : cur_dp[k]});
      chk($sformatf("dp_nb c%0d", i),    {6'b0, dp_nb}, {6'b0, g ? 1'b1 : ~cur_dp[k]});
      chk($sformatf("frame c%0d", i),    {6'b0, frame},    {6'b0, (i % 16) == 0});
      chk($sformatf("frame_hi c%0d", i), {6'b0, frame_hi}, {6'b0, (i % 16) == 0});
      chk($sformatf("frame_nb c%0d", i), {6'b0, frame_nb}, {6'b0, (i % 16) == 0});
    end
  endtask

  task automatic dark_now(input string tag);
    chk({tag, " an"},     {3'b0, an},    7'h0F);
    chk({tag, " seg"},    seg,           7'h7F);
    chk({tag, " dp"},     {6'b0, dp},    7'h01);
    chk({tag, " seg_hi"}, seg_hi,        7'h00);
    chk({tag, " dp_hi"},  {6'b0, dp_hi}, 7'h00);
    chk({tag, " frame"},  {6'b0, frame}, 7'h00);
  endtask

  task automatic dark(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dark_now($sformatf("dark c%0d", i));
    end
  endtask

  // Reset, load with scanning held, then enable so the next edge is cycle 1.
  task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic [3:0] blank);
    reset  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    value  = v;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    enable    = 1'b1;
    cur_val   = v;
    cur_dp    = d;
    cur_blank = blank;
  endtask

  initial begin
    tab[0]  = 7'b0111111; tab[1]  = 7'b0000110; tab[2]  = 7'b1011011; tab[3]  = 7'b1001111;
    tab[4]  = 7'b1100110; tab[5]  = 7'b1101101; tab[6]  = 7'b1111101; tab[7]  = 7'b0000111;
    tab[8]  = 7'b1111111; tab[9]  = 7'b1101111; tab[10] = 7'b1110111; tab[11] = 7'b1111100;
    tab[12] = 7'b0111001; tab[13] = 7'b1011110; tab[14] = 7'b1111001; tab[15] = 7'b1110001;

    reset = 1'b1; enable = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
    cur_val = 16'h0; cur_dp = 4'h0; cur_blank = 4'b1110;
    repeat (2) @(negedge clk);
    dark_now("reset");

    // Release with no load: digit 0 shows 0, upper digits blank
    reset = 1'b0;
    scan(1, 8);

    restart(16'h12AF, 4'b0100, 4'b0000);
    scan(1, 20);

    restart(16'h0030, 4'b0000, 4'b1100);
    scan(1, 16);

    // Enable dropped mid-slot for 10 cycles, then resume mid-slot on digit 1
    restart(16'h12AF, 4'b0100, 4'b0000);
    scan(1, 6);
    enable = 1'b0;
    dark(10);
    enable = 1'b1;
    scan(7, 20);

    // Load on the tick edge: digit 1 lights with the new nibble
    restart(16'h12AF, 4'b0100, 4'b0000);
    scan(1, 3);
    value = 16'h1275;
    load  = 1'b1;
    scan(4, 4);
    load    = 1'b0;
    cur_val = 16'h1275;
    scan(5, 8);

    // Asynchronous reset mid-slot darkens immediately, restart at digit 0
    #2 reset = 1'b1;
    #1 dark_now("async");
    @(negedge clk);
    reset = 1'b0;
    cur_val = 16'h0; cur_dp = 4'h0; cur_blank = 4'b1110;
    scan(1, 6);

    for (int n = 0; n < 16; n++) begin
      restart({12'h0, 4'(n)}, 4'b0000, 4'b1110);
      scan(1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
